// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, instruction-cache address view and frame.
// Field widths follow the default instruction-cache geometry.
package cpu_types_pkg;

    localparam int WORD_W       = 32;
    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = WORD_W - ICACHE_IDX_W - 2;

    typedef logic [WORD_W-1:0] word_t;

    // Fetch address as seen by the instruction cache.
    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    // One direct-mapped frame: a single instruction word.
    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    function automatic icachef_t split_iaddr(input word_t a);
        return icachef_t'(a);
    endfunction

endpackage

// File: rtl/icache_if.sv
// Cache interface: datapath fetch port and memory-controller read port.
// master = the cache itself, slave = datapath plus memory controller.
interface icache_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;

    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport master (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport slave (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache, one word per frame.
// Hits return in the request cycle; misses stall in MISS until memory answers.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = ICACHE_SETS
) (
    input  logic     CLK,
    input  logic     nRST,
    icache_if.master cif
);

    typedef enum logic {
        IDLE,
        MISS
    } state_t;

    // The address and frame layouts come from the shared package.
    if (SETS != ICACHE_SETS) begin : g_geom_check
        $error("icache: SETS must equal ICACHE_SETS");
    end

    state_t                  r_state;
    state_t                  w_next;
    word_t                   r_miss_addr;
    logic [SETS-1:0]         r_valid;
    logic [ICACHE_TAG_W-1:0] r_tag  [SETS];
    word_t                   r_data [SETS];

    icachef_t      w_req;
    icachef_t      w_fill_addr;
    icache_frame_t w_frame;
    logic          w_hit;
    logic          w_fill;
    logic          w_latch;
    logic          w_unused_ok;

    assign w_req       = split_iaddr(cif.imemaddr);
    assign w_fill_addr = split_iaddr(r_miss_addr);
    assign w_unused_ok = ^{w_req.bytoff, w_fill_addr.bytoff};

    assign w_frame = '{
        valid: r_valid[w_req.idx],
        tag:   r_tag[w_req.idx],
        data:  r_data[w_req.idx]
    };

    assign w_hit = cif.imemREN
                 & w_frame.valid
                 & (w_frame.tag == w_req.tag);

    // State and the address of the outstanding miss.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_state     <= IDLE;
            r_miss_addr <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_miss_addr <= cif.imemaddr;
            end
        end
    end

    // Valid bits: the only frame state that reset clears.
    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_fill_addr.idx] <= 1'b1;
        end
    end

    // Tag and data arrays: written on fill, overwriting any previous line.
    always_ff @(posedge CLK) begin
        if (w_fill) begin
            r_tag[w_fill_addr.idx]  <= w_fill_addr.tag;
            r_data[w_fill_addr.idx] <= cif.iload;
        end
    end

    // Next state, hit response and memory request.
    always_comb begin
        w_next       = r_state;
        w_fill       = 1'b0;
        w_latch      = 1'b0;
        cif.ihit     = 1'b0;
        cif.imemload = '0;
        cif.iREN     = 1'b0;
        cif.iaddr    = '0;
        unique case (r_state)
            IDLE: begin
                if (w_hit) begin
                    cif.ihit     = 1'b1;
                    cif.imemload = w_frame.data;
                end else if (cif.imemREN) begin
                    w_latch = 1'b1;
                    w_next  = MISS;
                end
            end
            MISS: begin
                cif.iREN  = 1'b1;
                cif.iaddr = r_miss_addr;
                if (!cif.iwait) begin
                    w_fill = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed fetch sequences, a word-level cache model
// checked every cycle, and literal expectations for latency and data.
module tb_icache;

    localparam int LAT = 2;

    logic CLK;
    logic nRST;
    int   n_checks;
    int   n_pass;

    icache_if cif();

    icache #(.SETS(16)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .cif  (cif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0040: return 32'h2001_0005;
            32'h0000_0440: return 32'h8C22_0000;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Memory controller: LAT busy cycles, then data for the requested word.
    int lat_cnt;
    always @(posedge CLK) begin
        #1;
        if (cif.iREN) begin
            if (lat_cnt < LAT) begin
                cif.iwait = 1'b1;
                cif.iload = 32'hDEAD_BEEF;
                lat_cnt++;
            end else begin
                cif.iwait = 1'b0;
                cif.iload = mem_word(cif.iaddr);
            end
        end else begin
            lat_cnt   = 0;
            cif.iwait = 1'b1;
            cif.iload = '0;
        end
    end

    // Model: each frame remembers which word address it holds; at most one
    // request is outstanding and it completes when memory stops waiting.
    bit          m_valid [16];
    logic [31:0] m_addr  [16];
    bit          m_pend;
    logic [31:0] m_paddr;

    always @(negedge CLK) begin
        logic        e_hit;
        logic        e_ren;
        logic [31:0] e_load;
        logic [31:0] e_addr;
        int          k;
        e_hit  = 1'b0;
        e_ren  = 1'b0;
        e_load = '0;
        e_addr = '0;
        k      = int'(cif.imemaddr[5:2]);
        if (!nRST) begin
            if (m_pend) begin
                e_ren  = 1'b1;
                e_addr = m_paddr;
            end else begin
                e_hit = cif.imemREN && m_valid[k]
                      && (m_addr[k][31:2] == cif.imemaddr[31:2]);
                if (e_hit) e_load = mem_word(cif.imemaddr);
            end
        end
        check("cyc_ihit",     {31'd0, cif.ihit}, {31'd0, e_hit});
        check("cyc_imemload", cif.imemload, e_load);
        check("cyc_iREN",     {31'd0, cif.iREN}, {31'd0, e_ren});
        check("cyc_iaddr",    cif.iaddr, e_addr);
        if (nRST) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_pend = 1'b0;
        end else if (m_pend) begin
            if (!cif.iwait) begin
                m_valid[int'(m_paddr[5:2])] = 1'b1;
                m_addr[int'(m_paddr[5:2])]  = m_paddr;
                m_pend = 1'b0;
            end
        end else if (cif.imemREN && !e_hit) begin
            m_pend  = 1'b1;
            m_paddr = cif.imemaddr;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Wait for ihit on the current request; check latency, memory
    // request cycles and returned word.
    task automatic wait_hit(input string name,
                            input logic [31:0] a,
                            input int exp_cyc,
                            input int exp_ren);
        int n;
        int ren_n;
        bit got;
        n     = 0;
        ren_n = 0;
        got   = 1'b0;
        while (!got && n < 40) begin
            @(negedge CLK);
            if (cif.ihit) begin
                got = 1'b1;
            end else begin
                if (cif.iREN) ren_n++;
                n++;
                tick();
            end
        end
        check({name, "_hit"}, {31'd0, got}, 32'd1);
        check({name, "_lat"}, n, exp_cyc);
        check({name, "_iren"}, ren_n, exp_ren);
        check({name, "_data"}, cif.imemload, mem_word(a));
        tick();
    endtask

    task automatic fetch(input string name,
                         input logic [31:0] a,
                         input int exp_cyc,
                         input int exp_ren);
        cif.imemREN  = 1'b1;
        cif.imemaddr = a;
        wait_hit(name, a, exp_cyc, exp_ren);
    endtask

    initial begin
        logic [31:0] idle_addrs [8];
        idle_addrs = '{32'h40, 32'h440, 32'h3C, 32'h80,
                       32'h84, 32'hFFFF_FFFC, 32'h0, 32'h1234_5678};
        n_checks     = 0;
        n_pass       = 0;
        m_pend       = 1'b0;
        m_paddr      = '0;
        nRST         = 1'b1;
        cif.imemREN  = 1'b0;
        cif.imemaddr = '0;
        cif.iwait    = 1'b1;
        cif.iload    = '0;
        foreach (m_valid[i]) begin
            m_valid[i] = 1'b0;
            m_addr[i]  = '0;
        end

        @(negedge CLK);
        check("rst_ihit",     {31'd0, cif.ihit}, 32'd0);
        check("rst_iREN",     {31'd0, cif.iREN}, 32'd0);
        check("rst_iaddr",    cif.iaddr, 32'd0);
        check("rst_imemload", cif.imemload, 32'd0);
        tick();
        tick();
        nRST = 1'b0;

        fetch("cold_40",  32'h0000_0040, 4, 3);
        fetch("refetch",  32'h0000_0040, 0, 0);
        fetch("conf_440", 32'h0000_0440, 4, 3);
        fetch("evict_40", 32'h0000_0040, 4, 3);
        fetch("top_3C",   32'h0000_003C, 4, 3);
        fetch("hit_3C",   32'h0000_003C, 0, 0);

        cif.imemREN  = 1'b1;
        cif.imemaddr = 32'h0000_0080;
        tick();
        cif.imemaddr = 32'h0000_0084;
        wait_hit("switch_84", 32'h0000_0084, 7, 6);
        fetch("kept_80",  32'h0000_0080, 0, 0);

        fetch("refill_40", 32'h0000_0040, 4, 3);
        fetch("warm_40",   32'h0000_0040, 0, 0);

        cif.imemaddr = 32'h0000_00C4;
        tick();
        tick();
        nRST = 1'b1;
        #1;
        check("rst_mid_iREN",  {31'd0, cif.iREN}, 32'd0);
        check("rst_mid_iaddr", cif.iaddr, 32'd0);
        tick();
        tick();
        nRST = 1'b0;
        fetch("post_rst_40", 32'h0000_0040, 4, 3);
        fetch("post_rst_C4", 32'h0000_00C4, 4, 3);

        for (int i = 0; i < 8; i++) begin
            cif.imemREN  = 1'b0;
            cif.imemaddr = idle_addrs[i];
            @(negedge CLK);
            check("noren_ihit", {31'd0, cif.ihit}, 32'd0);
            check("noren_iREN", {31'd0, cif.iREN}, 32'd0);
            check("noren_load", cif.imemload, 32'd0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter SETS, default 16, meaning number of direct-mapped frames (one 32-bit word each, power of 2).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 nRST  input  1  reset; asynchronous, active-high (1 = reset asserted).
REQ-004 imemREN  input  1  datapath instruction read request.
REQ-005 imemaddr  input  32  datapath fetch address (word aligned).
REQ-006 ihit  output  1  instruction valid on imemload this cycle.
REQ-007 imemload  output  32  fetched instruction.
REQ-008 iREN  output  1  read request to memory controller.
REQ-009 iaddr  output  32  memory read address.
REQ-010 iwait  input  1  memory busy; iload valid in the cycle iwait=0 while iREN=1.
REQ-011 iload  input  32  memory read data.

Function
REQ-012 Address split: byte offset [1:0] ignored, index [log2(SETS)+1:2], tag = remaining upper bits.
REQ-013 Each frame holds valid bit, tag, 32-bit data word.
REQ-014 FSM states: IDLE, MISS.
REQ-015 IDLE: hit = imemREN & frame[index].valid & tag match; ihit=hit and imemload=frame data combinationally, same cycle.
REQ-016 IDLE with imemREN=1 and no hit: latch imemaddr into miss_addr, next state MISS; ihit=0.
REQ-017 IDLE with imemREN=0: ihit=0, iREN=0, state holds.
REQ-018 MISS: iREN=1, iaddr=miss_addr, ihit=0; state holds while iwait=1.
REQ-019 MISS with iwait=0: write iload into frame at miss_addr index, set valid, write tag, next state IDLE; hit for that address available the following cycle.
REQ-020 Miss latency: ihit asserted (memory latency + 2) cycles after the miss cycle, i.e. one cycle after fill.
REQ-021 imemaddr change or imemREN deassertion during MISS does not abort the fill; the fill completes to miss_addr and IDLE re-evaluates the current request.
REQ-022 Conflict (same index, different tag): fill overwrites the frame unconditionally; no write-back (read-only cache).
REQ-023 iREN=0 and iaddr=0 in IDLE.
REQ-024 imemload = 0 when ihit=0.

Reset
REQ-025 nRST=1 asynchronously forces state=IDLE, all valid bits=0, miss_addr=0; outputs ihit=0, iREN=0, iaddr=0, imemload=0.
REQ-026 Reset during MISS abandons the fill; no frame is written; first request after release is a miss.
REQ-027 Tag and data arrays need not be reset; only valid bits are.

Structure
REQ-028 Address view struct (tag, idx, bytoff) and frame struct (valid, tag, data) shall be typedefs in cpu_types_pkg alongside word_t.
REQ-029 FSM state enum is local to icache.
REQ-030 No sub-module; frame array, FSM and hit compare are implemented inline.
REQ-031 Datapath-side and memory-side ports shall be grouped as modports of the existing cache interface used by the datapath.

Verification
REQ-032 Cold miss: imemREN=1, imemaddr=0x00000040, iwait=1 for 2 cycles then 0 with iload=0x20010005 -> iREN=1 for 3 cycles with iaddr=0x00000040, ihit=1 with imemload=0x20010005 the next cycle.
REQ-033 Re-fetch 0x00000040 -> ihit=1 same cycle, iREN stays 0.
REQ-034 Conflict: fetch 0x00000440 (same index 0, tag 0x11) with iload=0x8C220000 -> miss and fill; then fetch 0x00000040 -> miss again (evicted).
REQ-035 Address change mid-miss: start miss at 0x00000080, switch imemaddr to 0x00000084 before iwait drops -> frame for 0x80 filled, then new miss issued for 0x84.
REQ-036 Reset mid-miss: assert nRST during MISS -> iREN=0 immediately, after release fetch of previously filled 0x00000040 misses.
REQ-037 imemREN=0 with any address -> ihit=0, iREN=0, imemload=0 indefinitely.
